// File: rtl/fetch_request_tracker_pkg.sv
// Shared types for the fetch request tracker: per-request attributes, the
// tracked entry (attributes + stale bit) and the RISC-V control-flow opcode check.
package fetch_request_tracker_pkg;

    localparam int unsigned SUBUNIT_ID_W = 8;

    localparam logic [4:0] JAL_T    = 5'b11011;
    localparam logic [4:0] JALR_T   = 5'b11001;
    localparam logic [4:0] BRANCH_T = 5'b11000;

    typedef struct packed {
        logic [SUBUNIT_ID_W-1:0] subunit_id;
        logic                    address_valid;
        logic                    mmu_fault;
        logic                    predicted;
        logic                    is_branch;
        logic [31:0]             pc_plus_4;
    } fetch_attr_t;

    typedef struct packed {
        fetch_attr_t attr;
        logic        stale;
    } fetch_tracker_entry_t;

    function automatic logic is_branch_or_jump(input logic [31:0] instruction);
        logic [4:0] opcode;
        opcode = instruction[6:2];
        return (opcode == JAL_T) || (opcode == JALR_T) || (opcode == BRANCH_T);
    endfunction

endpackage

// File: rtl/fetch_request_tracker_buffer.sv
// Circular storage for outstanding fetch requests: pointers, occupancy count
// and per-entry stale marking so any number of back-to-back flushes is handled.
module fetch_request_tracker_buffer
    import fetch_request_tracker_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  fetch_attr_t                push_attr,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_tracker_entry_t       head_entry,
    output logic                       head_valid,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic [$clog2(DEPTH):0]     count_next
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    fetch_attr_t        attr_q [DEPTH];
    logic [DEPTH-1:0]   stale_q, stale_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [PTR_W:0]     count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        stale_d = stale_q;
        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end
        if (push) begin
            tail_d          = tail_q + PTR_W'(1);
            stale_d[tail_q] = 1'b0;
        end
        // A flush poisons everything that survives the edge, including this cycle's push.
        if (flush) begin
            stale_d = '1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            stale_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            stale_q <= stale_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            attr_q[tail_q] <= push_attr;
        end
    end

    always_comb begin
        head_entry.attr  = attr_q[head_q];
        head_entry.stale = stale_q[head_q];
    end

    assign head_valid = (count_q != '0);
    assign full       = (count_q == (PTR_W+1)'(DEPTH));
    assign count      = count_q;
    assign count_next = count_d;

endmodule

// File: rtl/fetch_request_tracker.sv
// In-order tracker for outstanding instruction fetches: retires the head entry,
// steers sub-unit data to decode, detects predictor corruption and gates ifences.
module fetch_request_tracker
    import fetch_request_tracker_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING          = 4,
    parameter int unsigned NUM_SUB_UNITS            = 3,
    parameter bit          INCLUDE_CORRUPTION_CHECK = 1'b1,
    localparam int unsigned SUB_W = (NUM_SUB_UNITS > 1) ? $clog2(NUM_SUB_UNITS) : 1,
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_push,
    input  logic [SUB_W-1:0]               req_subunit_id,
    input  logic                           req_address_valid,
    input  logic                           req_mmu_fault,
    input  logic                           req_predicted,
    input  logic                           req_is_branch,
    input  logic [31:0]                    req_pc_plus_4,
    input  logic                           gc_fetch_flush,
    input  logic                           ifence_req,
    input  logic [NUM_SUB_UNITS-1:0]       unit_data_valid,
    input  logic [NUM_SUB_UNITS-1:0][31:0] unit_data,
    output logic                           full,
    output logic [CNT_W-1:0]               inflight_count,
    output logic                           fetch_complete,
    output logic                           fetch_ok,
    output logic                           fetch_mmu_fault,
    output logic [31:0]                    fetch_instruction,
    output logic                           early_branch_flush,
    output logic                           early_branch_flush_ras_adjust,
    output logic [31:0]                    early_flush_pc,
    output logic                           issue_hold,
    output logic                           ifence_start
);
    fetch_attr_t            push_attr;
    fetch_tracker_entry_t   head;
    logic                   head_valid;
    logic                   push_accept;
    logic                   pop;
    logic                   flush;
    logic [CNT_W-1:0]       count_next;
    logic [NUM_SUB_UNITS-1:0] head_unit_mask;
    logic                   head_unit_valid;
    logic                   ifence_pending_q, ifence_pending_d;

    always_comb begin
        push_attr.subunit_id    = SUBUNIT_ID_W'(req_subunit_id);
        push_attr.address_valid = req_address_valid;
        push_attr.mmu_fault     = req_mmu_fault;
        push_attr.predicted     = req_predicted;
        push_attr.is_branch     = req_is_branch;
        push_attr.pc_plus_4     = req_pc_plus_4;
    end

    // The pop frees the head slot at the same edge, so a push at full is legal with a pop.
    assign push_accept = req_push & (~full | pop);

    fetch_request_tracker_buffer #(
        .DEPTH      (MAX_OUTSTANDING)
    ) buffer_i (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_accept),
        .push_attr  (push_attr),
        .pop        (pop),
        .flush      (flush),
        .head_entry (head),
        .head_valid (head_valid),
        .full       (full),
        .count      (inflight_count),
        .count_next (count_next)
    );

    always_comb begin
        head_unit_mask    = '0;
        fetch_instruction = '0;
        for (int i = 0; i < NUM_SUB_UNITS; i++) begin
            if (head.attr.subunit_id == SUBUNIT_ID_W'(i)) begin
                head_unit_mask[i] = head_valid;
                fetch_instruction = unit_data[i];
            end
        end
        head_unit_valid = |(unit_data_valid & head_unit_mask);
    end

    // Stale and invalid/faulted heads retire without waiting for sub-unit data.
    always_comb begin
        fetch_ok        = head_valid & head.attr.address_valid & ~head.attr.mmu_fault;
        pop             = rst_n & head_valid & (head.stale | ~fetch_ok | head_unit_valid);
        fetch_complete  = pop & ~head.stale;
        fetch_mmu_fault = head.attr.mmu_fault;
        early_flush_pc  = head.attr.pc_plus_4;
    end

    always_comb begin
        early_branch_flush            = 1'b0;
        early_branch_flush_ras_adjust = 1'b0;
        if (INCLUDE_CORRUPTION_CHECK) begin
            early_branch_flush = fetch_complete & fetch_ok & head.attr.predicted
                               & ~is_branch_or_jump(fetch_instruction);
            early_branch_flush_ras_adjust = early_branch_flush & head.attr.is_branch;
        end
        flush = gc_fetch_flush | early_branch_flush;
    end

    always_comb begin
        issue_hold       = ifence_pending_q;
        ifence_start     = rst_n & ifence_pending_q & (count_next == '0);
        ifence_pending_d = ifence_pending_q ? ~ifence_start : ifence_req;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ifence_pending_q <= 1'b0;
        end else begin
            ifence_pending_q <= ifence_pending_d;
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(req_push && full && !pop))
                else $error("fetch_request_tracker: push while full");
            assert ((unit_data_valid & ~head_unit_mask) == '0)
                else $error("fetch_request_tracker: spurious sub-unit data");
        end
    end

endmodule

// File: tb/tb_fetch_request_tracker.sv
// Scoreboard bench for fetch_request_tracker: a queue-based model issues random
// requests/responses/flushes/fences; a monitor compares DUT outputs every cycle.
module tb_fetch_request_tracker;
    localparam int MAX   = 4;
    localparam int NSU   = 3;
    localparam int SUB_W = 2;
    localparam int CNT_W = 3;

    logic                  clk;
    logic                  rst_n;
    logic                  req_push;
    logic [SUB_W-1:0]      req_subunit_id;
    logic                  req_address_valid;
    logic                  req_mmu_fault;
    logic                  req_predicted;
    logic                  req_is_branch;
    logic [31:0]           req_pc_plus_4;
    logic                  gc_fetch_flush;
    logic                  ifence_req;
    logic [NSU-1:0]        unit_data_valid;
    logic [NSU-1:0][31:0]  unit_data;
    logic                  full;
    logic [CNT_W-1:0]      inflight_count;
    logic                  fetch_complete;
    logic                  fetch_ok;
    logic                  fetch_mmu_fault;
    logic [31:0]           fetch_instruction;
    logic                  early_branch_flush;
    logic                  early_branch_flush_ras_adjust;
    logic [31:0]           early_flush_pc;
    logic                  issue_hold;
    logic                  ifence_start;

    fetch_request_tracker #(
        .MAX_OUTSTANDING(MAX), .NUM_SUB_UNITS(NSU), .INCLUDE_CORRUPTION_CHECK(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_push(req_push), .req_subunit_id(req_subunit_id),
        .req_address_valid(req_address_valid), .req_mmu_fault(req_mmu_fault),
        .req_predicted(req_predicted), .req_is_branch(req_is_branch),
        .req_pc_plus_4(req_pc_plus_4), .gc_fetch_flush(gc_fetch_flush),
        .ifence_req(ifence_req), .unit_data_valid(unit_data_valid), .unit_data(unit_data),
        .full(full), .inflight_count(inflight_count), .fetch_complete(fetch_complete),
        .fetch_ok(fetch_ok), .fetch_mmu_fault(fetch_mmu_fault),
        .fetch_instruction(fetch_instruction), .early_branch_flush(early_branch_flush),
        .early_branch_flush_ras_adjust(early_branch_flush_ras_adjust),
        .early_flush_pc(early_flush_pc), .issue_hold(issue_hold), .ifence_start(ifence_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          sub;
        bit          av;
        bit          fault;
        bit          pred;
        bit          br;
        bit          stale;
        logic [31:0] pc;
    } ment_t;

    typedef struct {
        int cnt;
        bit full, cmpl, ok, early, ras, hold, ifs;
    } ecyc_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        bit          fault;
    } ecmp_t;

    ment_t mq[$];
    ecyc_t cyc_q[$];
    ecmp_t cmp_q[$];
    bit    pending;

    int n_cmp = 0;
    int n_bad = 0;

    int fault_pct = 0;
    int inv_pct   = 0;
    int pred_pct  = 0;
    bit force_addi = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_bj(input logic [31:0] instr);
        logic [6:0] op;
        op = instr[6:0];
        return (op == 7'b1101111) || (op == 7'b1100111) || (op == 7'b1100011);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 4))
            0: r[6:0] = 7'b1101111;
            1: r[6:0] = 7'b1100111;
            2: r[6:0] = 7'b1100011;
            3: r = 32'h0000_0013;
            default: r[1:0] = 2'b11;
        endcase
        return r;
    endfunction

    // One clock of stimulus; the model decides every expected output for this cycle.
    task automatic do_cycle(input bit want_push, input bit want_data, input bit gc,
                            input bit ifq, input bit rst_lo);
        ecyc_t ec;
        ecmp_t cc;
        ment_t ne;
        bit    okh, dv, pop, cmpl, early, ras, push_acc, flush;
        int    cnt_next;
        logic [31:0] instr;

        @(posedge clk);
        #1;
        for (int i = 0; i < NSU; i++) begin
            unit_data[i] = force_addi ? 32'h0000_0013 : rand_instr();
        end
        unit_data_valid = '0;
        okh = 0; dv = 0; pop = 0; cmpl = 0; early = 0; ras = 0; instr = '0;
        if (mq.size() != 0) begin
            okh   = mq[0].av && !mq[0].fault;
            instr = unit_data[mq[0].sub];
            if (!rst_lo) begin
                if (!mq[0].stale && okh && want_data) begin
                    unit_data_valid[mq[0].sub] = 1'b1;
                    dv = 1;
                end
                pop  = mq[0].stale || !okh || dv;
                cmpl = pop && !mq[0].stale;
                early = cmpl && okh && mq[0].pred && !is_bj(instr);
                ras   = early && mq[0].br;
            end
        end

        push_acc = want_push && !rst_lo && !pending && (mq.size() < MAX || pop);
        ne.sub   = $urandom_range(0, NSU - 1);
        ne.av    = ($urandom_range(0, 99) >= inv_pct);
        ne.fault = ($urandom_range(0, 99) < fault_pct);
        ne.pred  = ($urandom_range(0, 99) < pred_pct);
        ne.br    = $urandom_range(0, 1);
        ne.stale = 0;
        ne.pc    = $urandom;
        req_push          = push_acc;
        req_subunit_id    = SUB_W'(ne.sub);
        req_address_valid = ne.av;
        req_mmu_fault     = ne.fault;
        req_predicted     = ne.pred;
        req_is_branch     = ne.br;
        req_pc_plus_4     = ne.pc;
        gc_fetch_flush    = gc && !rst_lo;
        ifence_req        = ifq && !rst_lo;
        rst_n             = !rst_lo;

        flush    = !rst_lo && (gc || early);
        cnt_next = mq.size() - int'(pop) + int'(push_acc);
        ec.cnt   = mq.size();
        ec.full  = (mq.size() == MAX);
        ec.cmpl  = cmpl;
        ec.ok    = okh;
        ec.early = early;
        ec.ras   = ras;
        ec.hold  = pending;
        ec.ifs   = !rst_lo && pending && (cnt_next == 0);
        cyc_q.push_back(ec);
        if (cmpl) begin
            cc.instr = instr;
            cc.pc    = mq[0].pc;
            cc.fault = mq[0].fault;
            cmp_q.push_back(cc);
        end

        if (rst_lo) begin
            mq.delete();
            pending = 0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push_acc) mq.push_back(ne);
            if (flush) foreach (mq[k]) mq[k].stale = 1;
            pending = pending ? !ec.ifs : ifq;
        end
    endtask

    initial begin : monitor
        ecyc_t ec;
        ecmp_t cc;
        forever begin
            @(negedge clk);
            if (cyc_q.size() != 0) begin
                ec = cyc_q.pop_front();
                chk("inflight_count", 32'(inflight_count), ec.cnt);
                chk("full", 32'(full), 32'(ec.full));
                chk("fetch_complete", 32'(fetch_complete), 32'(ec.cmpl));
                chk("fetch_ok", 32'(fetch_ok), 32'(ec.ok));
                chk("early_branch_flush", 32'(early_branch_flush), 32'(ec.early));
                chk("ras_adjust", 32'(early_branch_flush_ras_adjust), 32'(ec.ras));
                chk("issue_hold", 32'(issue_hold), 32'(ec.hold));
                chk("ifence_start", 32'(ifence_start), 32'(ec.ifs));
            end
            if (fetch_complete === 1'b1) begin
                if (cmp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL completion: got unexpected fetch_complete, want none at %0t", $time);
                end else begin
                    cc = cmp_q.pop_front();
                    chk("fetch_instruction", fetch_instruction, cc.instr);
                    chk("early_flush_pc", early_flush_pc, cc.pc);
                    chk("fetch_mmu_fault", 32'(fetch_mmu_fault), 32'(cc.fault));
                end
            end
        end
    end

    initial begin
        rst_n = 0; req_push = 0; req_subunit_id = '0; req_address_valid = 0;
        req_mmu_fault = 0; req_predicted = 0; req_is_branch = 0; req_pc_plus_4 = '0;
        gc_fetch_flush = 0; ifence_req = 0; unit_data_valid = '0; unit_data = '0;
        pending = 0;
        repeat (2) @(posedge clk);
        do_cycle(0, 0, 0, 0, 1);

        // Fill to full, push+pop at full, then drain in order.
        repeat (4) do_cycle(1, 0, 0, 0, 0);
        do_cycle(0, 0, 0, 0, 0);
        do_cycle(1, 1, 0, 0, 0);
        repeat (8) do_cycle(0, 1, 0, 0, 0);

        // Three in flight, three consecutive flushes, then a normal request.
        repeat (3) do_cycle(1, 0, 0, 0, 0);
        repeat (3) do_cycle(0, 0, 1, 0, 0);
        repeat (4) do_cycle(0, 0, 0, 0, 0);
        do_cycle(1, 0, 0, 0, 0);
        repeat (3) do_cycle(0, 1, 0, 0, 0);

        // MMU-faulted pseudo-request.
        fault_pct = 100;
        do_cycle(1, 0, 0, 0, 0);
        fault_pct = 0;
        repeat (2) do_cycle(0, 0, 0, 0, 0);

        // Predicted non-branch triggers the corruption flush.
        pred_pct = 100; force_addi = 1;
        repeat (2) do_cycle(1, 0, 0, 0, 0);
        pred_pct = 0;
        repeat (4) do_cycle(0, 1, 0, 0, 0);
        force_addi = 0;

        // ifence with two entries in flight.
        repeat (2) do_cycle(1, 0, 0, 0, 0);
        do_cycle(0, 0, 0, 1, 0);
        repeat (6) do_cycle(1, 1, 0, 0, 0);

        // Reset mid-stream.
        repeat (3) do_cycle(1, 0, 0, 0, 0);
        do_cycle(0, 1, 0, 0, 1);
        repeat (2) do_cycle(0, 1, 0, 0, 0);

        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) begin
                fault_pct = $urandom_range(0, 30);
                inv_pct   = $urandom_range(0, 30);
                pred_pct  = $urandom_range(0, 60);
            end
            do_cycle($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60,
                     $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 3,
                     $urandom_range(0, 999) < 3);
        end

        repeat (12) do_cycle(0, 1, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("pending_completions", cmp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
